rnq_arbiter: RTL
================

# rnq_arbiter

Write-port arbiter and read scheduler for the rename queue. Two decode-side requesters (req0: primary decode slot, req1: replay/secondary slot) share the queue's single write port under round-robin. The block also issues reads toward the issue stage from a locally tracked occupancy count and enforces a post-flush quiet window after `mispredict`/`flush_fCOM`. It sits between decode and the rename queue and drives the queue's `do_write`/`do_read`/`data_in`.

## Interface
- `ENTRY_W`, 160, queue entry width
- `DEPTH`, 8, queue depth; must match the queue
- `CNT_W`, 4, occupancy width (holds 0..DEPTH)
- `FLUSH_HOLD`, 2, quiet cycles after a flush event (≥1)

- `CLK`  in  1  clock
- `RESET`  in  1  asynchronous, active-low reset
- `FREEZE`  in  1  pipeline stall
- `mispredict`, `flush_fCOM`  in  1 each  flush events
- `req0_valid`, `req1_valid`  in  1 each  requester has an entry
- `req0_data`, `req1_data`  in  ENTRY_W each  requester payload
- `req0_grant`, `req1_grant`  out  1 each  payload accepted this cycle
- `q_do_write`  out  1  queue write strobe
- `q_data_in`  out  ENTRY_W  queue write data
- `q_do_read`  out  1  queue read/pop strobe
- `q_empty`, `q_full`  in  1 each  queue status, used for consistency check only
- `cons_ready`  in  1  issue stage takes head entry
- `cons_valid`  out  1  head entry valid for issue
- `occupancy`  out  CNT_W  tracked entry count
- `flushing`  out  1  state == FLUSH
- `err`  out  1  sticky tracking mismatch

## Operation
- States: RUN, FLUSH. Reset → RUN, occupancy 0, round-robin pointer favours req0, hold counter 0, err 0. All grants/strobes are combinational and 0 during reset.
- `flush_evt` = `mispredict | flush_fCOM`. Takes priority over everything, including FREEZE. In the `flush_evt` cycle, grants, `q_do_write`, `q_do_read` and `cons_valid` are 0. Next state is FLUSH, hold = FLUSH_HOLD−1, occupancy ← 0. A `flush_evt` during FLUSH reloads the hold counter.
- FLUSH: no grants, no reads, `cons_valid`=0. Hold decrements only when !FREEZE. When hold==0 and !FREEZE, next state is RUN.
- RUN, `wr_ok` = !FREEZE & occupancy<DEPTH:
  - Only one requester valid → grant it.
  - Both valid → grant the one opposite the last granted; pointer updates only on a grant.
  - `q_do_write` = OR of grants; `q_data_in` = granted payload, or req0_data when idle.
- A write is refused at occupancy==DEPTH even if a read occurs in the same cycle, matching the queue's full check.
- `cons_valid` = RUN & occupancy≠0 & !FREEZE. `q_do_read` = `cons_valid & cons_ready`.
- Occupancy: +1 on write only, −1 on read only, unchanged on both or neither. Never wraps; saturation is impossible by construction.
- `err` is set in RUN when (occupancy==0)≠`q_empty` or (occupancy==DEPTH)≠`q_full`. It is cleared only by RESET.

## Timing
- Grant and write have zero latency: granted data enters the queue on the same edge. A requester holds `valid`/`data` until it sees its grant.
- Occupancy, state, pointer and hold update on the posedge.
- Reset mid-operation clears all state asynchronously. Outputs go to 0 immediately.
- FREEZE freezes all registers except the flush response.
- Minimum gap from `flush_evt` to first grant is FLUSH_HOLD+1 cycles, with FREEZE low.

## Test plan
- Reset, then req0 valid alone for 3 cycles with data 1,2,3 → req0_grant=1 each cycle; occupancy 1,2,3; `cons_valid`=1 after the first edge.
- Both requesters continuously valid → grants alternate req0, req1, req0, …. After 8 writes with no reads, occupancy=8 and grants are 0 while both stay valid.
- Occupancy 8, `cons_ready`=1 and both requesters valid for 1 cycle → read occurs, write refused, occupancy 7. Next cycle: write and read together → occupancy stays 7.
- Occupancy 5, pulse `mispredict` with FREEZE=1 → that cycle grants and read are 0. Occupancy 0, FLUSH for 2 cycles once FREEZE drops, then RUN. First grant exactly 3 cycles after the pulse.
- FREEZE=1 with requesters valid and `cons_ready`=1 → no grants or reads; occupancy and pointer unchanged.
- Drive `q_empty`=0 while occupancy=0 in RUN → `err`=1 and stays 1 through a flush; cleared only by RESET.

Source files
------------

// File: rtl/rnq_arbiter.sv
// Rename-queue write-port arbiter (round-robin between two decode slots) and
// read scheduler with locally tracked occupancy and a post-flush quiet window.
module rnq_arbiter #(
  parameter int ENTRY_W    = 160,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 4,
  parameter int FLUSH_HOLD = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FREEZE,
  input  logic               mispredict,
  input  logic               flush_fCOM,
  input  logic               req0_valid,
  input  logic               req1_valid,
  input  logic [ENTRY_W-1:0] req0_data,
  input  logic [ENTRY_W-1:0] req1_data,
  output logic               req0_grant,
  output logic               req1_grant,
  output logic               q_do_write,
  output logic [ENTRY_W-1:0] q_data_in,
  output logic               q_do_read,
  input  logic               q_empty,
  input  logic               q_full,
  input  logic               cons_ready,
  output logic               cons_valid,
  output logic [CNT_W-1:0]   occupancy,
  output logic               flushing,
  output logic               err
);

  localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLUSH_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic [HOLD_W-1:0]   hold_q;
  logic                prio_q, prio_d;  // 0: req0 wins a tie, 1: req1 wins
  logic                err_q;

  logic flush_evt, is_run, wr_ok, g0, g1, wr, rd, mismatch;

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    flush_evt = mispredict | flush_fCOM;
    is_run    = (state_q == RUN);
    wr_ok     = is_run & ~flush_evt & ~FREEZE & (occ_q != CNT_FULL);
    g0        = wr_ok & req0_valid & (~req1_valid | ~prio_q);
    g1        = wr_ok & req1_valid & (~req0_valid |  prio_q);
    wr        = g0 | g1;
    rd        = is_run & ~flush_evt & ~FREEZE & (occ_q != '0) & cons_ready;
    mismatch  = is_run & ~FREEZE &
                (((occ_q == '0) != q_empty) | ((occ_q == CNT_FULL) != q_full));

    occ_d = occ_q;
    case ({wr, rd})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    prio_d = prio_q;
    if (g0)      prio_d = 1'b1;
    else if (g1) prio_d = 1'b0;
  end

  // Strobes are forced low while RESET is asserted, independent of the clock.
  assign req0_grant = g0 & RESET;
  assign req1_grant = g1 & RESET;
  assign q_do_write = wr & RESET;
  assign q_do_read  = rd & RESET;
  assign cons_valid = is_run & ~flush_evt & ~FREEZE & (occ_q != '0) & RESET;
  assign q_data_in  = g1 ? req1_data : req0_data;
  assign occupancy  = occ_q;
  assign flushing   = (state_q == FLUSH);
  assign err        = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= RUN;
      occ_q   <= '0;
      hold_q  <= '0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (mismatch) err_q <= 1'b1;

      if (flush_evt) begin
        // Flush overrides FREEZE and restarts the quiet window.
        state_q <= FLUSH;
        hold_q  <= HOLD_INIT;
        occ_q   <= '0;
      end else if (!FREEZE) begin
        case (state_q)
          RUN: begin
            occ_q  <= occ_d;
            prio_q <= prio_d;
          end
          FLUSH: begin
            if (hold_q == '0) state_q <= RUN;
            else              hold_q  <= hold_q - 1'b1;
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

endmodule
